// File: rtl/pe_pkg.sv
// Shared constants, types and helpers for the convolution processing element.
// Default window geometry and operand widths live here. The helper that sizes
// the accumulator also lives here, so instantiating code can compute a safe
// RESULT_W the same way the PE checks it.
package pe_pkg;

    // Default kernel edge and operand widths.
    localparam int KERNEL_DEF   = 5;
    localparam int PIC_W_DEF    = 16;
    localparam int WEIGHT_W_DEF = 16;

    // Width of the window counter.
    // Ten bits cover kernels up to 32x32 (1024 products per window).
    localparam int CNT_W = 10;

    // Type used to index products within one window.
    typedef logic [CNT_W-1:0] win_cnt_t;

    // Smallest accumulator width that can hold a full window sum exactly.
    // The sum of kernel*kernel products of pic_w x weight_w operands can grow
    // by at most clog2(kernel*kernel) bits over a single product.
    function automatic int min_result_w(input int kernel,
                                        input int pic_w,
                                        input int weight_w);
        return pic_w + weight_w + $clog2(kernel * kernel);
    endfunction

    // Default accumulator width derived from the defaults above (37 bits).
    localparam int RESULT_W_DEF = min_result_w(KERNEL_DEF, PIC_W_DEF, WEIGHT_W_DEF);

endpackage : pe_pkg

// File: rtl/pe_mult.sv
// Combinational pixel x weight multiplier for the processing element.
// The product is extended to the full accumulator width, so the caller can
// add it directly. Define PE_SIGNED_EN to treat both operands as two's
// complement (sign extension). Leave it undefined for unsigned operands
// (zero extension).
module pe_mult
    import pe_pkg::*;
#(
    parameter int PIC_W    = PIC_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int RESULT_W = RESULT_W_DEF
)
(
    input  logic [PIC_W-1:0]    pic_dat,
    input  logic [WEIGHT_W-1:0] weight_dat,
    output logic [RESULT_W-1:0] prod
);

`ifdef PE_SIGNED_EN
    logic signed [RESULT_W-1:0] pic_ext;
    logic signed [RESULT_W-1:0] weight_ext;

    // Sign-extend both operands to the accumulator width before multiplying.
    // Keeping only the low RESULT_W bits is exact, because the true product
    // always fits in RESULT_W bits.
    always_comb begin
        pic_ext    = RESULT_W'($signed(pic_dat));
        weight_ext = RESULT_W'($signed(weight_dat));
        prod       = pic_ext * weight_ext;
    end
`else
    logic [RESULT_W-1:0] pic_ext;
    logic [RESULT_W-1:0] weight_ext;

    // Zero-extend both operands and form the exact unsigned product.
    always_comb begin
        pic_ext    = RESULT_W'(pic_dat);
        weight_ext = RESULT_W'(weight_dat);
        prod       = pic_ext * weight_ext;
    end
`endif

endmodule : pe_mult

// File: rtl/pe.sv
// Processing element: multiply-accumulates one pixel/weight pair per clock
// over a KERNEL x KERNEL window. It then emits the window sum with a one-cycle
// valid pulse and restarts from zero with no gap. PE_SIGNED_EN selects signed
// operands; the default build is unsigned. In the signed build, result carries
// the two's-complement window sum.
// rst_n is a synchronous, active-high reset despite its name.
module pe
    import pe_pkg::*;
#(
    parameter int KERNEL   = KERNEL_DEF,
    parameter int PIC_W    = PIC_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int RESULT_W = 37
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIC_W-1:0]    picDat,
    input  logic [WEIGHT_W-1:0] weightDat,
    output logic [RESULT_W-1:0] result,
    output logic                valid
);

    localparam int       WIN_LEN  = KERNEL * KERNEL;
    localparam win_cnt_t LAST_IDX = win_cnt_t'(WIN_LEN - 1);

    // Refuse to build an accumulator that could overflow.
    // Also refuse a window the counter cannot index.
    if (RESULT_W < min_result_w(KERNEL, PIC_W, WEIGHT_W)) begin : g_result_w_check
        $error("pe: RESULT_W=%0d is below the minimum %0d",
               RESULT_W, min_result_w(KERNEL, PIC_W, WEIGHT_W));
    end
    if (WIN_LEN > (2 ** CNT_W)) begin : g_kernel_check
        $error("pe: KERNEL=%0d exceeds the window counter range", KERNEL);
    end

    logic [RESULT_W-1:0] prod;
    logic [RESULT_W-1:0] acc;
    logic [RESULT_W-1:0] acc_sum;
    win_cnt_t            cnt;

    pe_mult #(
        .PIC_W    (PIC_W),
        .WEIGHT_W (WEIGHT_W),
        .RESULT_W (RESULT_W)
    ) u_mult (
        .pic_dat    (picDat),
        .weight_dat (weightDat),
        .prod       (prod)
    );

    // Running sum including the pair sampled this cycle.
    // The width rule guarantees this addition never wraps.
    assign acc_sum = acc + prod;

    // Window sequencing, accumulation and the registered result/valid outputs.
    // On the last product of a window, the full sum goes straight to result,
    // and the accumulator is cleared so the next window starts the following
    // cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            valid  <= 1'b0;
        end else if (cnt == LAST_IDX) begin
            result <= acc_sum;
            valid  <= 1'b1;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            acc    <= acc_sum;
            cnt    <= cnt + 1'b1;
            valid  <= 1'b0;
        end
    end

endmodule : pe

// File: tb/tb_pe.sv
// Self-checking bench for the processing element (default parameters).
// The reference model collects each window's pairs in queues. When a window
// is complete, the model sums the products with plain integer arithmetic.
// It honours PE_SIGNED_EN, as the design does.
module tb_pe;

    localparam int KERNEL   = 5;
    localparam int PIC_W    = 16;
    localparam int WEIGHT_W = 16;
    localparam int RESULT_W = 37;
    localparam int WIN_LEN  = KERNEL * KERNEL;

    logic                clk;
    logic                rst_n;
    logic [PIC_W-1:0]    picDat;
    logic [WEIGHT_W-1:0] weightDat;
    logic [RESULT_W-1:0] result;
    logic                valid;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [PIC_W-1:0]    win_pic[$];
    logic [WEIGHT_W-1:0] win_wgt[$];
    logic [RESULT_W-1:0] exp_result;
    logic                exp_valid;
    int                  edges_since_reset;

    pe #(
        .KERNEL   (KERNEL),
        .PIC_W    (PIC_W),
        .WEIGHT_W (WEIGHT_W),
        .RESULT_W (RESULT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .picDat    (picDat),
        .weightDat (weightDat),
        .result    (result),
        .valid     (valid)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value of one operand as the model interprets it.
    function automatic longint opVal(input logic [15:0] v);
`ifdef PE_SIGNED_EN
        return longint'($signed(v));
`else
        return longint'(v);
`endif
    endfunction

    // Compare an observed value against the model's expectation.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model at the edge, then check the outputs
    // shortly after the edge.
    task automatic applyStimulus(input logic r, input logic [15:0] p, input logic [15:0] w);
        longint sum;
        rst_n     = r;
        picDat    = p;
        weightDat = w;
        @(posedge clk);
        if (r) begin
            win_pic.delete();
            win_wgt.delete();
            exp_result        = '0;
            exp_valid         = 1'b0;
            edges_since_reset = 0;
        end else begin
            edges_since_reset++;
            win_pic.push_back(p);
            win_wgt.push_back(w);
            exp_valid = 1'b0;
            if (win_pic.size() == WIN_LEN) begin
                sum = 0;
                foreach (win_pic[i]) sum += opVal(win_pic[i]) * opVal(win_wgt[i]);
                exp_result = sum[RESULT_W-1:0];
                exp_valid  = 1'b1;
                win_pic.delete();
                win_wgt.delete();
            end
        end
        #1;
        checkOutput("valid", 64'(valid), 64'(exp_valid));
        checkOutput("result", 64'(result), 64'(exp_result));
    endtask

    initial begin
        logic [RESULT_W-1:0] want;
        exp_result        = '0;
        exp_valid         = 1'b0;
        edges_since_reset = 0;
        rst_n     = 1'b1;
        picDat    = '0;
        weightDat = '0;

        // Reset values: reset held for 2 cycles with nonzero inputs.
        applyStimulus(1'b1, 16'h1234, 16'h5678);
        applyStimulus(1'b1, 16'hABCD, 16'h0042);

        // Basic window: constant 1x1 over two windows.
        // The first pulse must land on the 25th edge after reset.
        for (int i = 0; i < 2 * WIN_LEN; i++) begin
            applyStimulus(1'b0, 16'd1, 16'd1);
            if (i == WIN_LEN - 1) begin
                checkOutput("first_valid_edge", 64'(valid), 64'd1);
                checkOutput("first_valid_index", 64'(edges_since_reset), 64'd25);
                checkOutput("basic_result", 64'(result), 64'd25);
            end
        end
        checkOutput("basic_second", 64'(result), 64'd25);

        // Mid-window reset drops the partial sum.
        applyStimulus(1'b1, 16'd0, 16'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 16'd1, 16'd1);
        applyStimulus(1'b1, 16'd1, 16'd1);
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(1'b0, 16'd1, 16'd1);
        checkOutput("midreset_valid", 64'(valid), 64'd1);
        checkOutput("midreset_result", 64'(result), 64'd25);

        // Largest operands: 0xFFFF x 0xFFFF.
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
`ifdef PE_SIGNED_EN
        want = 37'd25;
`else
        want = 37'd107370905625;
`endif
        checkOutput("max_operands", 64'(result), 64'(want));

        // Negative pixel against a small weight.
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(1'b0, 16'hFFFF, 16'd2);
`ifdef PE_SIGNED_EN
        want = 37'h1F_FFFF_FFCE;
`else
        want = 37'd3276750;
`endif
        checkOutput("neg_by_two", 64'(result), 64'(want));

        // Ramp k = 0..24 times 1, then an all-zero window.
        for (int k = 0; k < WIN_LEN; k++) applyStimulus(1'b0, 16'(k), 16'd1);
        checkOutput("ramp_sum", 64'(result), 64'd300);
        for (int i = 0; i < WIN_LEN; i++) applyStimulus(1'b0, 16'd0, 16'd0);
        checkOutput("zero_window", 64'(result), 64'd0);

        // Random data with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pe
